serial_adder_ctrl: RTL and testbench

Bit-serial adder sequencer placed directly around the team's `fulladder` stage. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake. Each clock it drives one bit pair and the registered carry into the external full adder, then captures that adder's sum and carry outputs. After WIDTH cycles it presents the assembled sum and carry-out over an output valid/ready handshake.

---
 rtl/serial_adder_ctrl.sv | 114 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer wrapped around an external one-bit full adder stage.
// Latency: out_valid rises WIDTH edges after the accepting edge; one op per WIDTH+2 cycles minimum.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry_q;
  logic [CW-1:0]    count;
  logic             last_bit;
  logic             run;

  // Sum bits arrive LSB first and enter at the MSB end, so after WIDTH shifts they line up.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nxt = fa_sum;
    end else begin : g_wn
      assign sum_nxt = {fa_sum, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign run      = (state == RUN);
  assign last_bit = (count == CW'(WIDTH - 1));

  assign fa_a = run & a_sh[0];
  assign fa_b = run & b_sh[0];
  assign fa_c = run & carry_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry_q   <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= op_a;
            b_sh     <= op_b;
            carry_q  <= cin;
            count    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          sum_sh  <= sum_nxt;
          carry_q <= fa_carry;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          count   <= count + CW'(1);
          if (last_bit) begin
            // The result register is separate so sum/cout survive the next RUN.
            sum       <= sum_nxt;
            cout      <= fa_carry;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 with a behavioural full adder.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       in_valid, in_ready, cin, fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic       out_valid, out_ready, cout, busy;
  logic [7:0] op_a, op_b, sum;

  logic       in_valid_w1, in_ready_w1, cin_w1, fa_a_w1, fa_b_w1, fa_c_w1, fa_sum_w1, fa_carry_w1;
  logic       out_valid_w1, out_ready_w1, cout_w1, busy_w1;
  logic [0:0] op_a_w1, op_b_w1, sum_w1;

  assign fa_sum      = fa_a ^ fa_b ^ fa_c;
  assign fa_carry    = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);
  assign fa_sum_w1   = fa_a_w1 ^ fa_b_w1 ^ fa_c_w1;
  assign fa_carry_w1 = (fa_a_w1 & fa_b_w1) | (fa_a_w1 & fa_c_w1) | (fa_b_w1 & fa_c_w1);

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c), .fa_sum(fa_sum), .fa_carry(fa_carry),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_w1), .in_ready(in_ready_w1),
    .op_a(op_a_w1), .op_b(op_b_w1), .cin(cin_w1),
    .fa_a(fa_a_w1), .fa_b(fa_b_w1), .fa_c(fa_c_w1), .fa_sum(fa_sum_w1), .fa_carry(fa_carry_w1),
    .out_valid(out_valid_w1), .out_ready(out_ready_w1), .sum(sum_w1), .cout(cout_w1), .busy(busy_w1)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [7:0] fa_trace;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit keep);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    cin      = c;
    if (keep) q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
  endtask

  // Called on the negedge right after the accepting edge; records fa_a during RUN.
  task automatic wait8(output int lat);
    lat      = 0;
    fa_trace = '0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (lat < 8) fa_trace[lat] = fa_a;
      tick();
      lat++;
    end
  endtask

  task automatic pop8(output logic [8:0] e);
    if (q8.size() > 0) e = q8.pop_front();
    else e = 'x;
  endtask

  task automatic drain8();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, cout} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl in_ready/out_valid/busy/cout=%b exp 1000", {in_ready, out_valid, busy, cout});
    end
    checks++;
    if (sum !== 8'h00 || {fa_a, fa_b, fa_c} !== 3'b000) begin
      errors++;
      $display("FAIL reset_data sum=%h fa=%b exp sum=00 fa=000", sum, {fa_a, fa_b, fa_c});
    end
    checks++;
    if ({in_ready_w1, out_valid_w1, busy_w1, cout_w1, sum_w1} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_w1 got %b exp 10000", {in_ready_w1, out_valid_w1, busy_w1, cout_w1, sum_w1});
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [8:0] e;
    start8(8'h5A, 8'h3C, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_run_flags in_ready=%b busy=%b exp 0 1", in_ready, busy);
    end
    wait8(lat);
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL basic_latency got %0d exp 8", lat);
    end
    checks++;
    if (fa_trace !== 8'h5A) begin
      errors++;
      $display("FAIL basic_fa_a_seq got %b exp 01011010 (LSB first)", fa_trace);
    end
    pop8(e);
    checks++;
    if ({cout, sum} !== e || e !== 9'h096) begin
      errors++;
      $display("FAIL basic_result got %h exp %h", {cout, sum}, e);
    end
    drain8();
  endtask

  task automatic test_carry();
    logic [7:0] a_tab[2] = '{8'hFF, 8'hFF};
    logic [7:0] b_tab[2] = '{8'h01, 8'hFF};
    logic       c_tab[2] = '{1'b0, 1'b1};
    int lat;
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      start8(a_tab[i], b_tab[i], c_tab[i], 1'b1);
      tick();
      in_valid = 1'b0;
      wait8(lat);
      pop8(e);
      checks++;
      if ({cout, sum} !== e) begin
        errors++;
        $display("FAIL carry_result_%0d got %h exp %h", i, {cout, sum}, e);
      end
      drain8();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit hold_ok;
    logic [8:0] e;
    start8(8'h5A, 8'h3C, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    wait8(lat);
    pop8(e);
    checks++;
    if ({cout, sum} !== e) begin
      errors++;
      $display("FAIL bp_result got %h exp %h", {cout, sum}, e);
    end
    in_valid = 1'b1;
    op_a     = 8'h11;
    op_b     = 8'h22;
    cin      = 1'b0;
    hold_ok  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid !== 1'b1 || {cout, sum} !== e || in_ready !== 1'b0) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL bp_hold out_valid=%b result=%h in_ready=%b exp 1 %h 0", out_valid, {cout, sum}, in_ready, e);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || {cout, sum} !== e) begin
      errors++;
      $display("FAIL bp_transfer out_valid=%b in_ready=%b busy=%b result=%h exp 0 1 0 %h",
               out_valid, in_ready, busy, {cout, sum}, e);
    end
    q8.push_back(9'h011 + 9'h022);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait8(lat);
    pop8(e);
    checks++;
    if (lat != 8 || {cout, sum} !== e) begin
      errors++;
      $display("FAIL bp_next_op lat=%0d result=%h exp lat=8 result=%h", lat, {cout, sum}, e);
    end
    drain8();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit quiet;
    logic [8:0] e;
    start8(8'h5A, 8'h3C, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, busy, out_valid, fa_a, fa_b, fa_c} !== 6'b100000 || {cout, sum} !== 9'h000) begin
      errors++;
      $display("FAIL midrst_state in_ready/busy/out_valid/fa=%b result=%h exp 100000 000",
               {in_ready, busy, out_valid, fa_a, fa_b, fa_c}, {cout, sum});
    end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL midrst_no_output out_valid=%b busy=%b exp 0 0", out_valid, busy);
    end
    start8(8'h10, 8'h20, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    wait8(lat);
    pop8(e);
    checks++;
    if ({cout, sum} !== e || e !== 9'h030) begin
      errors++;
      $display("FAIL midrst_fresh got %h exp %h", {cout, sum}, e);
    end
    drain8();
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int first = -1;
    int second = -1;
    logic [8:0] e;
    out_ready = 1'b1;
    start8(8'h01, 8'h01, 1'b0, 1'b1);
    tick();
    start8(8'h80, 8'h80, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
      if (out_valid === 1'b1) begin
        pop8(e);
        checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL b2b_result_%0d got %h exp %h", got, {cout, sum}, e);
        end
        if (got == 0) first = cyc;
        else second = cyc;
        got++;
        if (got == 2) in_valid = 1'b0;
      end
      if (got < 2) tick();
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 2 || second - first != 10) begin
      errors++;
      $display("FAIL b2b_spacing results=%0d gap=%0d exp 2 results gap 10", got, second - first);
    end
    checks++;
    if (q8.size() != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle pending=%0d in_ready=%b exp 0 1", q8.size(), in_ready);
    end
  endtask

  task automatic test_width1();
    int lat;
    logic [1:0] e;
    in_valid_w1 = 1'b1;
    op_a_w1     = 1'b1;
    op_b_w1     = 1'b1;
    cin_w1      = 1'b1;
    q1.push_back({1'b0, op_a_w1} + {1'b0, op_b_w1} + 2'(cin_w1));
    tick();
    in_valid_w1 = 1'b0;
    checks++;
    if ({fa_a_w1, fa_b_w1, fa_c_w1} !== 3'b111) begin
      errors++;
      $display("FAIL w1_fa got %b exp 111", {fa_a_w1, fa_b_w1, fa_c_w1});
    end
    lat = 0;
    while (out_valid_w1 !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    e = (q1.size() > 0) ? q1.pop_front() : 2'bxx;
    checks++;
    if (lat != 1 || {cout_w1, sum_w1} !== e) begin
      errors++;
      $display("FAIL w1_result lat=%0d result=%b exp lat=1 result=%b", lat, {cout_w1, sum_w1}, e);
    end
    out_ready_w1 = 1'b1;
    tick();
    out_ready_w1 = 1'b0;
    checks++;
    if (in_ready_w1 !== 1'b1 || out_valid_w1 !== 1'b0) begin
      errors++;
      $display("FAIL w1_return in_ready=%b out_valid=%b exp 1 0", in_ready_w1, out_valid_w1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    op_a         = '0;
    op_b         = '0;
    cin          = 1'b0;
    out_ready    = 1'b0;
    in_valid_w1  = 1'b0;
    op_a_w1      = '0;
    op_b_w1      = '0;
    cin_w1       = 1'b0;
    out_ready_w1 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
